mmio_bus_ctrl: RTL
==================

// Module: mmio_bus_ctrl
// PURPOSE
//  Memory-mapped I/O controller between the single-cycle RISC-V core's data port and its three slaves:
//  data memory, keyboard receiver and VGA typewriter.
//  Decodes the byte address, gates per-slave write strobes and muxes read data.
//  Buffers keyboard scan codes in an RX FIFO (read-to-pop).
//  Decouples CPU stores to the display through a TX FIFO drained by a ready/valid handshake.
// PARAMETERS
//  IO_BASE      456  first I/O byte address; addresses below it are data memory
//  KBD_DEPTH    8    RX FIFO entries (power of 2, >=2)
//  DISP_DEPTH   4    TX FIFO entries (power of 2, >=2)
// PORTS
//  clk_pix      in   1   CPU/pixel-domain clock; all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  mem_we       in   1   CPU store strobe
//  mem_re       in   1   CPU load strobe (asserted for load instructions only)
//  mem_addr     in   32  CPU byte address
//  mem_wdata    in   32  CPU store data
//  mem_rdata    out  32  read data to CPU, combinational
//  dmem_we      out  1   write enable to data memory
//  dmem_rdata   in   32  read data from data memory
//  key_code     in   8   scan code from keyboard receiver
//  key_ready    in   1   keyboard data-ready level, asynchronous to clk_pix
//  shift        in   3   modifier state, captured with key_code
//  disp_valid   out  1   TX FIFO head valid to display
//  disp_data    out  32  TX FIFO head word
//  disp_ready   in   1   display accepts head when disp_valid & disp_ready
//  irq_kbd      out  1   level: RX FIFO not empty
// BEHAVIOUR
//  Address map (word-aligned; addr[1:0] ignored inside the I/O space):
//   <IO_BASE      -> dmem; dmem_we = mem_we; mem_rdata = dmem_rdata
//   IO_BASE+0     KBD_DATA  R: {21'b0, shift, code} of RX head, 0 if empty; mem_re pops one entry at the edge
//   IO_BASE+4     KBD_STAT  R: {24'b0, count[3:0], 2'b0, ovf, nempty}; W: any write clears ovf
//   IO_BASE+8     DISP_DATA W: push mem_wdata into TX FIFO; R: 0
//   IO_BASE+12    DISP_STAT R: {29'b0, drop, full, empty}; W: any write clears drop
//   others >=IO_BASE: R 0; writes ignored; dmem_we=0
//  Keyboard capture: key_ready passes a 2-flop synchronizer; a rising edge on the synchronized level pushes {shift, key_code}.
//   key_code/shift are sampled in the same cycle the edge is detected.
//   Push to a full RX FIFO drops the code and sets ovf (sticky).
//   Push and pop in the same cycle: both take effect; count is unchanged.
//   Pop when empty: no effect.
//  Display: a store to DISP_DATA while full drops the word and sets drop (sticky). A store while not full pushes.
//   disp_valid = !tx_empty; disp_data = head, stable while disp_valid & !disp_ready.
//   A push and a handshake in the same cycle are both honoured, including when full: the handshake frees a slot first.
//  Sticky clear and a new set in the same cycle: the set wins.
//  Latency: write strobe/read mux are combinational. An RX code is readable 3 clk_pix after the raw key_ready rise.
//   A TX word is visible on disp_data the cycle after the store edge.
//  Reset (async, rst_n=0): both FIFO pointers/counts = 0, ovf = drop = 0, sync flops = 0.
//   Outputs: disp_valid=0, disp_data=0, irq_kbd=0, dmem_we follows mem_we combinationally.
//   Mid-operation reset discards all buffered entries. A key_ready held high through reset release does not push.
// STRUCTURE
//  Shared package mmio_pkg: IO_BASE offsets (KBD_DATA=0, KBD_STAT=4, DISP_DATA=8, DISP_STAT=12), status bit positions.
//  One sub-module, sync_fifo #(WIDTH, DEPTH): ptrs, count, full/empty, simultaneous push/pop.
//   Instantiated twice: RX at width 11, TX at width 32.
//  Decoder, synchronizer/edge detect, sticky bits and read mux stay in this module.
// TESTING
//  1 Reset then store 0xAB at addr 16 -> dmem_we=1, no FIFO change. Load addr 16 -> mem_rdata = dmem_rdata.
//  2 key_code=0x1C, shift=3'b010, key_ready 0->1 -> after 3 clks KBD_STAT=0x11, irq_kbd=1.
//    Load KBD_DATA -> 0x21C; next cycle KBD_STAT=0, irq_kbd=0.
//  3 Push 9 key edges without reads (DEPTH 8) -> count=8, ovf=1. First 8 codes read back in order.
//    Write KBD_STAT -> ovf=0.
//  4 disp_ready=0, store 5 words to DISP_DATA -> DISP_STAT full=1, drop=1.
//    disp_data holds word0. Raise disp_ready -> words 0..3 emitted one per clk, then disp_valid=0.
//  5 TX full and disp_ready=1 with a store in the same cycle -> no drop, count stays 4.
//    RX pop coincident with key edge -> count unchanged.
//  6 Assert rst_n=0 mid-burst with both FIFOs nonempty -> all outputs and status 0 immediately.
//    key_ready held high across release -> no push.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared address map, status bit positions and the address decoder for the
// MMIO controller sitting between the RISC-V data port and its slaves.
package mmio_pkg;

    localparam logic [31:0] OFF_KBD_DATA  = 32'd0;
    localparam logic [31:0] OFF_KBD_STAT  = 32'd4;
    localparam logic [31:0] OFF_DISP_DATA = 32'd8;
    localparam logic [31:0] OFF_DISP_STAT = 32'd12;

    localparam int KBD_NEMPTY_BIT = 0;
    localparam int KBD_OVF_BIT    = 1;
    localparam int KBD_CNT_LSB    = 4;
    localparam int DISP_EMPTY_BIT = 0;
    localparam int DISP_FULL_BIT  = 1;
    localparam int DISP_DROP_BIT  = 2;

    typedef enum logic [2:0] {
        SEL_DMEM      = 3'd0,
        SEL_KBD_DATA  = 3'd1,
        SEL_KBD_STAT  = 3'd2,
        SEL_DISP_DATA = 3'd3,
        SEL_DISP_STAT = 3'd4,
        SEL_NONE      = 3'd5
    } sel_e;

    // Word offsets inside the I/O window ignore the two byte-lane bits.
    function automatic sel_e decode(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        sel_e        sel;
        off = addr - base;
        if (addr < base) begin
            sel = SEL_DMEM;
        end else begin
            case ({off[31:2], 2'b00})
                OFF_KBD_DATA:  sel = SEL_KBD_DATA;
                OFF_KBD_STAT:  sel = SEL_KBD_STAT;
                OFF_DISP_DATA: sel = SEL_DISP_DATA;
                OFF_DISP_STAT: sel = SEL_DISP_STAT;
                default:       sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop in the same cycle frees the head slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             push_ok
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full_s    = (count_r == FULL_CNT);
    assign empty_s   = (count_r == {CW{1'b0}});
    assign pop_ok_s  = pop & ~empty_s;
    assign push_ok_s = push & (~full_s | pop_ok_s);

    assign head    = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign push_ok = push_ok_s;

    // Storage, pointers and occupancy; reset clears storage so the head reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO controller: decodes CPU data-port accesses into data memory, a keyboard
// RX FIFO with sticky overflow, and a display TX FIFO with sticky drop.
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] IO_BASE    = 32'd456,
    parameter int          KBD_DEPTH  = 8,
    parameter int          DISP_DEPTH = 4
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata,
    input  logic [7:0]  key_code,
    input  logic        key_ready,
    input  logic [2:0]  shift,
    output logic        disp_valid,
    output logic [31:0] disp_data,
    input  logic        disp_ready,
    output logic        irq_kbd
);

    localparam int RX_CW = $clog2(KBD_DEPTH) + 1;
    localparam int TX_CW = $clog2(DISP_DEPTH) + 1;

    sel_e             sel_s;
    logic [1:0]       sync_r;
    logic             key_prev_r;
    logic [1:0]       live_r;
    logic             armed_r;
    logic             key_edge_s;
    logic             rx_pop_s;
    logic [10:0]      rx_head_s;
    logic [RX_CW-1:0] rx_count_s;
    logic             rx_push_ok_s;
    logic             rx_nempty_s;
    logic [3:0]       rx_cnt4_s;
    logic             tx_push_s;
    logic             tx_pop_s;
    logic [31:0]      tx_head_s;
    logic [TX_CW-1:0] tx_count_s;
    logic             tx_push_ok_s;
    logic             tx_empty_s;
    logic             tx_full_s;
    logic             ovf_r;
    logic             drop_r;
    logic             ovf_set_s;
    logic             ovf_clr_s;
    logic             drop_set_s;
    logic             drop_clr_s;
    logic [31:0]      rdata_s;

    assign sel_s   = decode(mem_addr, IO_BASE);
    assign dmem_we = mem_we & (sel_s == SEL_DMEM);

    // Two-flop synchronizer plus edge detect; the arm flag needs a real low
    // level after reset so a key held through reset release never pushes.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            sync_r     <= 2'b00;
            key_prev_r <= 1'b0;
            live_r     <= 2'b00;
            armed_r    <= 1'b0;
        end else begin
            sync_r     <= {sync_r[0], key_ready};
            key_prev_r <= sync_r[1];
            live_r     <= {live_r[0], 1'b1};
            armed_r    <= armed_r | (live_r[1] & ~sync_r[1]);
        end
    end

    assign key_edge_s = sync_r[1] & ~key_prev_r & armed_r;
    assign rx_pop_s   = mem_re & (sel_s == SEL_KBD_DATA);

    sync_fifo #(.WIDTH(11), .DEPTH(KBD_DEPTH)) u_rx_fifo (
        .clk     (clk_pix),
        .rst_n   (rst_n),
        .push    (key_edge_s),
        .wdata   ({shift, key_code}),
        .pop     (rx_pop_s),
        .head    (rx_head_s),
        .count   (rx_count_s),
        .push_ok (rx_push_ok_s)
    );

    assign rx_nempty_s = (rx_count_s != {RX_CW{1'b0}});
    assign rx_cnt4_s   = 4'(rx_count_s);
    assign irq_kbd     = rx_nempty_s;

    assign tx_push_s = mem_we & (sel_s == SEL_DISP_DATA);
    assign tx_pop_s  = disp_valid & disp_ready;

    sync_fifo #(.WIDTH(32), .DEPTH(DISP_DEPTH)) u_tx_fifo (
        .clk     (clk_pix),
        .rst_n   (rst_n),
        .push    (tx_push_s),
        .wdata   (mem_wdata),
        .pop     (tx_pop_s),
        .head    (tx_head_s),
        .count   (tx_count_s),
        .push_ok (tx_push_ok_s)
    );

    assign tx_empty_s = (tx_count_s == {TX_CW{1'b0}});
    assign tx_full_s  = (tx_count_s == TX_CW'(DISP_DEPTH));
    assign disp_valid = ~tx_empty_s;
    assign disp_data  = tx_head_s;

    assign ovf_set_s  = key_edge_s & ~rx_push_ok_s;
    assign ovf_clr_s  = mem_we & (sel_s == SEL_KBD_STAT);
    assign drop_set_s = tx_push_s & ~tx_push_ok_s;
    assign drop_clr_s = mem_we & (sel_s == SEL_DISP_STAT);

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r  <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (drop_set_s) begin
                drop_r <= 1'b1;
            end else if (drop_clr_s) begin
                drop_r <= 1'b0;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    // Combinational read mux back to the CPU load path.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            SEL_DMEM: begin
                rdata_s = dmem_rdata;
            end
            SEL_KBD_DATA: begin
                if (rx_nempty_s) begin
                    rdata_s = {21'd0, rx_head_s};
                end else begin
                    rdata_s = 32'd0;
                end
            end
            SEL_KBD_STAT: begin
                rdata_s[KBD_CNT_LSB +: 4] = rx_cnt4_s;
                rdata_s[KBD_OVF_BIT]      = ovf_r;
                rdata_s[KBD_NEMPTY_BIT]   = rx_nempty_s;
            end
            SEL_DISP_STAT: begin
                rdata_s[DISP_DROP_BIT]  = drop_r;
                rdata_s[DISP_FULL_BIT]  = tx_full_s;
                rdata_s[DISP_EMPTY_BIT] = tx_empty_s;
            end
            default: begin
                rdata_s = 32'd0;
            end
        endcase
    end

    assign mem_rdata = rdata_s;

endmodule
